ram_wr_pack: RTL and testbench
==============================

Name: ram_wr_pack

Overview:
Parametrised successor to the upscaler-output RAM writer. Takes the pixel stream from the US block and writes it to a BRAM-style port (32-bit word, byte write-enables) starting at a programmable base address. Two modes: one pixel per word (zero-padded), or packed 24bpp (4 pixels into 3 words). Sequenced by FSM run/done: flushes a partial word at end of frame, then reports completion and the number of words written.

Parameters:
PIX_WIDTH, 24, pixel width in bits; must be ≤ 32; packed mode is legal only when PIX_WIDTH = 24.
ADDR_INC, 4, address increment per word written (byte addressing).
CNT_WIDTH, 20, width of the written-word counter.

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
run_i  in  1  level from FSM; rising into RUN starts a frame, dropping aborts it
base_addr_i  in  32  frame start byte address; sampled on the IDLE->RUN transition
pack_mode_i  in  1  0 = padded, 1 = packed 24bpp; sampled with base_addr_i; forced to 0 if PIX_WIDTH != 24
us_done_i  in  1  end-of-frame pulse from US
us_data_valid_i  in  1  pixel strobe; no backpressure
us_data_i  in  PIX_WIDTH  pixel
ram_addr_o  out  32  registered write address
ram_dout_o  out  32  registered write data
ram_en_o  out  1  registered port enable
ram_wr_en_o  out  4  registered byte enables
busy_o  out  1  high in RUN and FLUSH
done_o  out  1  one-cycle pulse when the frame is complete
word_cnt_o  out  CNT_WIDTH  words written in the current/last frame; holds after done

Behaviour:
- Reset (async, rst_n = 0) sets:
  - state IDLE
  - ram_addr_o, ram_dout_o, word_cnt_o, residue and phase = 0
  - ram_en_o = 0, ram_wr_en_o = 4'b0000, busy_o = 0, done_o = 0
- Reset mid-frame aborts immediately; no flush.
- Port outputs are registered: a pixel accepted in cycle N produces its write (if any) in cycle N+1.
- ram_en_o and ram_wr_en_o are 0 in every cycle without a write.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: on run_i = 1, latch base_addr_i and mode; addr = base; phase = 0; word_cnt = 0; go to RUN. Pixels are ignored.
  - RUN: each valid pixel is accepted (see modes below).
    - us_done_i = 1: go to FLUSH if the post-pixel phase != 0, else DONE. A valid pixel in the same cycle as us_done_i is accepted first.
    - run_i = 0: go to IDLE, discard residue, no done_o. Takes priority over us_done_i.
  - FLUSH: one cycle. Emit the partial word, then go to DONE.
  - DONE: done_o = 1 for this one cycle, then IDLE. Pixels are ignored in FLUSH and DONE.
- Padded mode, per pixel:
  - dout = zero-extended pixel; wr_en = 4'b1111 if PIX_WIDTH > 24, else 4'b0111.
  - addr advances by ADDR_INC after each write.
- Packed mode: phase counts 0..3 per pixel; P0..P3 are the pixels of a group of four.
  - phase 0 -> 1: residue = P0; no write.
  - phase 1 -> 2: write {P1[7:0], P0}; residue = P1[23:8].
  - phase 2 -> 3: write {P2[15:0], P1[23:8]}; residue = P2[23:16].
  - phase 3 -> 0: write {P3, P2[23:16]}.
  - Every write in this mode uses wr_en = 4'b1111.
- FLUSH word, by phase:
  - phase 1: {8'h0, residue[23:0]}, wr_en 4'b0111
  - phase 2: {16'h0, residue[15:0]}, wr_en 4'b0011
  - phase 3: {24'h0, residue[7:0]}, wr_en 4'b0001
- word_cnt increments on every write, including the flush write, and saturates at all-ones.
- Address wrap: 32-bit address wraps modulo 2^32 silently.

Optional Feature:
Macro RAM_WR_BOUND_EN.
- Defined: adds ports limit_addr_i (in, 32; sampled with base_addr_i) and err_o (out, 1).
  - Any write whose address is ≥ limit is suppressed: ram_en_o = 0, wr_en = 0, word_cnt unchanged. Address still advances.
  - err_o is set and stays sticky until the next IDLE->RUN transition or reset; reset value 0.
- Undefined: neither port exists and all writes are issued.

Test Plan:
- Padded mode: base = 0x1000, 3 pixels 0xAABBCC, 0x112233, 0x445566, then us_done_i. Required:
  - writes to 0x1000/0x1004/0x1008 with data 0x00AABBCC/0x00112233/0x00445566, wr_en 0111
  - no FLUSH; done_o one cycle; word_cnt_o = 3
- Packed mode: base = 0, pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A. Required:
  - words 0x04030201 @0, 0x08070605 @4, 0x0C0B0A09 @8
  - all wr_en 1111; word_cnt_o = 3
- Packed flush: 5 pixels, the 5th = 0x0F0E0D, with us_done_i in the same cycle as the 5th. Required:
  - 3 full words, then FLUSH write 0x000F0E0D @0xC with wr_en 0111
  - word_cnt_o = 4; done_o after the flush
- Abort: packed mode, 2 pixels, then run_i = 0. Required:
  - one write issued, state returns to IDLE, no done_o
  - next frame starts at the new base with phase 0
- Async reset: assert rst_n = 0 mid-frame between clock edges. Required:
  - all outputs 0 immediately; IDLE after release
- RAM_WR_BOUND_EN: base = 0, limit = 8, 4 padded pixels. Required:
  - writes @0 and @4 only; err_o = 1 from the @8 attempt onward
  - word_cnt_o = 2; err_o cleared on the next run start

Source files
------------

// File: rtl/ram_wr_pack.sv
// -----------------------------------------------------------------------------
// ram_wr_pack
//
// Writes the upscaler pixel stream into a 32-bit BRAM-style port with byte
// write-enables, starting at a programmable byte address. Two layouts:
//   padded : one pixel per word, zero-extended
//   packed : 24bpp, four pixels folded into three words (PIX_WIDTH = 24 only)
// A frame is bracketed by run_i (level) and us_done_i (pulse). Any bytes still
// held when the frame ends are written out as a final partial word, after which
// done_o pulses and word_cnt_o holds the number of words written.
//
// Optional build macro: RAM_WR_BOUND_EN
//   Adds limit_addr_i / err_o. Writes at or above the limit are dropped (the
//   address still advances) and err_o latches until the next frame start.
//
// Parameters:
//   PIX_WIDTH  pixel width in bits (<= 32)
//   ADDR_INC   byte address step per word written
//   CNT_WIDTH  width of the written-word counter (saturating)
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   run_i             frame enable level; rise starts, fall aborts
//   base_addr_i       frame start byte address, sampled at frame start
//   pack_mode_i       0 = padded, 1 = packed 24bpp, sampled at frame start
//   limit_addr_i      (RAM_WR_BOUND_EN) exclusive upper address bound
//   us_done_i         end-of-frame pulse
//   us_data_valid_i   pixel strobe (no backpressure)
//   us_data_i         pixel
//   ram_addr_o        write byte address (registered)
//   ram_dout_o        write data (registered)
//   ram_en_o          port enable (registered)
//   ram_wr_en_o       byte write enables (registered)
//   busy_o            frame in progress (RUN or FLUSH)
//   done_o            one-cycle frame-complete pulse
//   word_cnt_o        words written in the current/last frame
//   err_o             (RAM_WR_BOUND_EN) sticky out-of-bound write flag
// -----------------------------------------------------------------------------
module ram_wr_pack #(
  parameter int unsigned PIX_WIDTH = 24,
  parameter int unsigned ADDR_INC  = 4,
  parameter int unsigned CNT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run_i,
  input  logic [31:0]          base_addr_i,
  input  logic                 pack_mode_i,
`ifdef RAM_WR_BOUND_EN
  input  logic [31:0]          limit_addr_i,
  output logic                 err_o,
`endif
  input  logic                 us_done_i,
  input  logic                 us_data_valid_i,
  input  logic [PIX_WIDTH-1:0] us_data_i,
  output logic [31:0]          ram_addr_o,
  output logic [31:0]          ram_dout_o,
  output logic                 ram_en_o,
  output logic [3:0]           ram_wr_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] word_cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // Padded words only enable the bytes a pixel can occupy.
  localparam logic [3:0] PAD_BE  = (PIX_WIDTH > 24) ? 4'b1111 : 4'b0111;
  localparam bit         PACK_OK = (PIX_WIDTH == 24);

  state_t      state_q, state_d;
  logic [31:0] addr_q;       // address the next word will be written to
  logic [23:0] residue_q, residue_d;
  logic [1:0]  phase_q, phase_d;
  logic        packed_q;
  logic        start;
  logic        wr_req;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [31:0] pix32;
  logic        wr_ok;

  assign pix32  = 32'(us_data_i);
  assign busy_o = (state_q == RUN) || (state_q == FLUSH);
  assign done_o = (state_q == DONE);

`ifdef RAM_WR_BOUND_EN
  logic [31:0] limit_q;
  assign wr_ok = (addr_q < limit_q);
`else
  assign wr_ok = 1'b1;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    wr_req    = 1'b0;
    wr_data   = '0;
    wr_be     = '0;
    residue_d = residue_q;
    phase_d   = phase_q;
    unique case (state_q)
      IDLE: begin
        if (run_i) begin
          start   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort wins over everything else in this cycle, including a pixel.
        if (!run_i) begin
          state_d = IDLE;
        end else begin
          if (us_data_valid_i) begin
            if (!packed_q) begin
              wr_req  = 1'b1;
              wr_data = pix32;
              wr_be   = PAD_BE;
            end else begin
              // Bytes flow little-endian: each word takes the held residue
              // in its low bytes and tops up from the new pixel.
              phase_d = phase_q + 2'd1;
              case (phase_q)
                2'd0: residue_d = pix32[23:0];
                2'd1: begin
                  wr_req    = 1'b1;
                  wr_data   = {pix32[7:0], residue_q[23:0]};
                  wr_be     = 4'b1111;
                  residue_d = {8'h00, pix32[23:8]};
                end
                2'd2: begin
                  wr_req    = 1'b1;
                  wr_data   = {pix32[15:0], residue_q[15:0]};
                  wr_be     = 4'b1111;
                  residue_d = {16'h0000, pix32[23:16]};
                end
                default: begin
                  wr_req  = 1'b1;
                  wr_data = {pix32[23:0], residue_q[7:0]};
                  wr_be   = 4'b1111;
                end
              endcase
            end
          end
          // Decided on the phase after this cycle's pixel.
          if (us_done_i) state_d = (phase_d != 2'd0) ? FLUSH : DONE;
        end
      end
      FLUSH: begin
        wr_req  = 1'b1;
        state_d = DONE;
        case (phase_q)
          2'd1: begin
            wr_data = {8'h00, residue_q[23:0]};
            wr_be   = 4'b0111;
          end
          2'd2: begin
            wr_data = {16'h0000, residue_q[15:0]};
            wr_be   = 4'b0011;
          end
          default: begin
            wr_data = {24'h000000, residue_q[7:0]};
            wr_be   = 4'b0001;
          end
        endcase
      end
      DONE: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      residue_q   <= '0;
      phase_q     <= '0;
      packed_q    <= 1'b0;
      ram_addr_o  <= '0;
      ram_dout_o  <= '0;
      ram_en_o    <= 1'b0;
      ram_wr_en_o <= '0;
      word_cnt_o  <= '0;
`ifdef RAM_WR_BOUND_EN
      limit_q     <= '0;
      err_o       <= 1'b0;
`endif
    end else begin
      ram_en_o    <= 1'b0;
      ram_wr_en_o <= '0;
      residue_q   <= residue_d;
      phase_q     <= phase_d;
      if (start) begin
        addr_q     <= base_addr_i;
        packed_q   <= pack_mode_i && PACK_OK;
        phase_q    <= '0;
        residue_q  <= '0;
        word_cnt_o <= '0;
`ifdef RAM_WR_BOUND_EN
        limit_q    <= limit_addr_i;
        err_o      <= 1'b0;
`endif
      end else if (wr_req) begin
        // The address advances even for a dropped write so later words keep
        // their intended positions.
        addr_q <= addr_q + ADDR_INC;
        if (wr_ok) begin
          ram_en_o    <= 1'b1;
          ram_wr_en_o <= wr_be;
          ram_addr_o  <= addr_q;
          ram_dout_o  <= wr_data;
          if (word_cnt_o != '1) word_cnt_o <= word_cnt_o + CNT_WIDTH'(1);
        end
`ifdef RAM_WR_BOUND_EN
        else begin
          err_o <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_ram_wr_pack.sv
// -----------------------------------------------------------------------------
// tb_ram_wr_pack
//
// Self-checking bench for ram_wr_pack. The reference model treats a frame as a
// little-endian byte stream (packed) or one word per pixel (padded) and queues
// the expected writes with the cycle each must appear in. A negedge process
// compares the port against that queue every cycle and checks done_o and the
// final word count. Directed frames pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_ram_wr_pack;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run_i = 1'b0;
  logic [31:0]   base_addr_i = '0;
  logic          pack_mode_i = 1'b0;
  logic          us_done_i = 1'b0;
  logic          us_data_valid_i = 1'b0;
  logic [23:0]   us_data_i = '0;
  logic [31:0]   ram_addr_o;
  logic [31:0]   ram_dout_o;
  logic          ram_en_o;
  logic [3:0]    ram_wr_en_o;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] word_cnt_o;
`ifdef RAM_WR_BOUND_EN
  logic [31:0]   limit_addr_i = '1;
  logic          err_o;
`endif

  ram_wr_pack #(.PIX_WIDTH(24), .ADDR_INC(4), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run_i           (run_i),
    .base_addr_i     (base_addr_i),
    .pack_mode_i     (pack_mode_i),
`ifdef RAM_WR_BOUND_EN
    .limit_addr_i    (limit_addr_i),
    .err_o           (err_o),
`endif
    .us_done_i       (us_done_i),
    .us_data_valid_i (us_data_valid_i),
    .us_data_i       (us_data_i),
    .ram_addr_o      (ram_addr_o),
    .ram_dout_o      (ram_dout_o),
    .ram_en_o        (ram_en_o),
    .ram_wr_en_o     (ram_wr_en_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .word_cnt_o      (word_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          due;
    bit          supp;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } obs_t;

  wr_t         exp_q[$];
  obs_t        obs_q[$];
  logic [23:0] pix_q[$];
  logic [7:0]  m_bytes[$];
  logic [31:0] m_addr;
  logic [31:0] m_limit;
  bit          m_packed;
  bit          m_bound;
  int          m_cnt;
  int          exp_done_cyc  = -1;
  int          exp_done_cnt  = 0;
  int          start_cyc     = -1;
  int          last_ud_edge  = -1;
  int          last_done_cyc = -1;
  int          done_seen     = 0;
  bit          err_exp       = 1'b0;
  int          n_checks      = 0;
  int          n_fail        = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check("write_missing_due_cycle", 32'(cyc), 32'(exp_q[0].due));
        void'(exp_q.pop_front());
      end
`ifdef RAM_WR_BOUND_EN
      if (cyc == start_cyc) err_exp = 1'b0;
`endif
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        wr_t e;
        e = exp_q.pop_front();
        check("ram_en", 32'(ram_en_o), 32'(!e.supp));
        if (e.supp) begin
          check("wr_en_suppressed", 32'(ram_wr_en_o), 32'd0);
          err_exp = 1'b1;
        end else if (ram_en_o) begin
          check("ram_addr", ram_addr_o, e.addr);
          check("ram_dout", ram_dout_o, e.data);
          check("ram_wr_en", 32'(ram_wr_en_o), 32'(e.be));
          obs_q.push_back('{ram_addr_o, ram_dout_o, ram_wr_en_o});
        end
      end else begin
        check("ram_en_idle", 32'(ram_en_o), 32'd0);
        check("wr_en_idle", 32'(ram_wr_en_o), 32'd0);
      end
      check("done_o", 32'(done_o), 32'(cyc == exp_done_cyc));
      if (cyc == exp_done_cyc) check("word_cnt_at_done", 32'(word_cnt_o), 32'(exp_done_cnt));
      if (done_o) begin
        done_seen++;
        last_done_cyc = cyc;
      end
`ifdef RAM_WR_BOUND_EN
      check("err_o", 32'(err_o), 32'(err_exp));
`endif
    end
  end

  // ---------------------------------------------------------------- model
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [31:0] data, input logic [3:0] be, input int due);
    wr_t e;
    e.addr = m_addr;
    e.data = data;
    e.be   = be;
    e.due  = due;
    e.supp = m_bound && (m_addr >= m_limit);
    if (!e.supp && m_cnt < CNT_MAX) m_cnt++;
    exp_q.push_back(e);
    m_addr = m_addr + 32'd4;
  endtask

  task automatic model_pixel(input logic [23:0] p, input int due);
    logic [31:0] w;
    if (!m_packed) begin
      push_wr(32'(p), 4'b0111, due);
    end else begin
      m_bytes.push_back(p[7:0]);
      m_bytes.push_back(p[15:8]);
      m_bytes.push_back(p[23:16]);
      if (m_bytes.size() >= 4) begin
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = m_bytes.pop_front();
        push_wr(w, 4'b1111, due);
      end
    end
  endtask

  // Called while us_done_i is being set up for the next edge.
  task automatic finish_model();
    int          ud;
    int          n;
    logic [31:0] w;
    logic [3:0]  be;
    ud = cyc + 1;
    last_ud_edge = ud;
    n = m_bytes.size();
    if (n > 0) begin
      w  = '0;
      be = '0;
      for (int i = 0; i < n; i++) begin
        w[8*i +: 8] = m_bytes[i];
        be[i]       = 1'b1;
      end
      m_bytes.delete();
      push_wr(w, be, ud + 1);
      exp_done_cyc = ud + 1;
    end else begin
      exp_done_cyc = ud;
    end
    exp_done_cnt = m_cnt;
  endtask

  // ---------------------------------------------------------------- stimulus
  task automatic start_frame(input logic [31:0] base, input bit pk, input logic [31:0] limit);
    run_i           = 1'b1;
    base_addr_i     = base;
    pack_mode_i     = pk;
    us_data_valid_i = 1'b0;
    us_done_i       = 1'b0;
`ifdef RAM_WR_BOUND_EN
    limit_addr_i    = limit;
    m_bound         = 1'b1;
`else
    m_bound         = 1'b0;
`endif
    m_limit   = limit;
    m_addr    = base;
    m_packed  = pk;
    m_cnt     = 0;
    m_bytes.delete();
    start_cyc = cyc + 1;
    step();
    // Changing these after the start must have no effect on the frame.
    base_addr_i = $urandom;
    pack_mode_i = ~pk;
  endtask

  task automatic feed(input logic [23:0] p, input bit with_done);
    us_data_valid_i = 1'b1;
    us_data_i       = p;
    us_done_i       = with_done;
    model_pixel(p, cyc + 1);
    if (with_done) finish_model();
    step();
    us_data_valid_i = 1'b0;
    us_done_i       = 1'b0;
  endtask

  // Pixels come from pix_q. abort_at >= 0 drops run_i after that many pixels.
  task automatic run_frame(input logic [31:0] base, input bit pk, input logic [31:0] limit,
                           input bit done_with_last, input int abort_at, input bit gaps);
    int n;
    n = pix_q.size();
    start_frame(base, pk, limit);
    for (int i = 0; i < n; i++) begin
      if (abort_at == i) break;
      if (gaps) repeat ($urandom_range(0, 2)) step();
      feed(pix_q[i], done_with_last && (i == n - 1) && (abort_at < 0));
    end
    if (abort_at >= 0) begin
      run_i = 1'b0;
      m_bytes.delete();
      step();
      repeat (2) step();
      return;
    end
    if (!(done_with_last && n > 0)) begin
      us_done_i = 1'b1;
      finish_model();
      step();
      us_done_i = 1'b0;
    end
    run_i = 1'b0;
    // Pixels after the end of frame must be ignored.
    repeat (3) begin
      us_data_valid_i = 1'($urandom);
      us_data_i       = 24'($urandom);
      step();
    end
    us_data_valid_i = 1'b0;
  endtask

  initial begin
    // ---------------- reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_addr", ram_addr_o, 32'd0);
    check("rst_ram_dout", ram_dout_o, 32'd0);
    check("rst_ram_en", 32'(ram_en_o), 32'd0);
    check("rst_wr_en", 32'(ram_wr_en_o), 32'd0);
    check("rst_word_cnt", 32'(word_cnt_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    rst_n = 1'b1;
    step();

    // ---------------- padded, three pixels, separate done
    pix_q = '{24'hAABBCC, 24'h112233, 24'h445566};
    obs_q.delete();
    run_frame(32'h1000, 1'b0, 32'hFFFF_FFFF, 1'b0, -1, 1'b0);
    check("pad_nwr", 32'(obs_q.size()), 32'd3);
    if (obs_q.size() == 3) begin
      check("pad_a0", obs_q[0].addr, 32'h1000);
      check("pad_d0", obs_q[0].data, 32'h00AABBCC);
      check("pad_a2", obs_q[2].addr, 32'h1008);
      check("pad_d2", obs_q[2].data, 32'h00445566);
      check("pad_be1", 32'(obs_q[1].be), 32'h7);
    end
    check("pad_cnt", 32'(word_cnt_o), 32'd3);
    check("pad_done_no_flush", 32'(last_done_cyc - last_ud_edge), 32'd0);
    check("pad_busy_after", 32'(busy_o), 32'd0);

    // ---------------- packed, four pixels
    pix_q = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};
    obs_q.delete();
    run_frame(32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, -1, 1'b0);
    check("pk_nwr", 32'(obs_q.size()), 32'd3);
    if (obs_q.size() == 3) begin
      check("pk_d0", obs_q[0].data, 32'h04030201);
      check("pk_d1", obs_q[1].data, 32'h08070605);
      check("pk_d2", obs_q[2].data, 32'h0C0B0A09);
      check("pk_a2", obs_q[2].addr, 32'h8);
      check("pk_be0", 32'(obs_q[0].be), 32'hF);
    end
    check("pk_cnt", 32'(word_cnt_o), 32'd3);

    // ---------------- packed flush, done with fifth pixel
    pix_q = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A, 24'h0F0E0D};
    obs_q.delete();
    run_frame(32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, -1, 1'b0);
    check("fl_nwr", 32'(obs_q.size()), 32'd4);
    if (obs_q.size() == 4) begin
      check("fl_d3", obs_q[3].data, 32'h000F0E0D);
      check("fl_a3", obs_q[3].addr, 32'hC);
      check("fl_be3", 32'(obs_q[3].be), 32'h7);
    end
    check("fl_cnt", 32'(word_cnt_o), 32'd4);
    check("fl_done_after_flush", 32'(last_done_cyc - last_ud_edge), 32'd1);

    // ---------------- abort after two packed pixels, then a fresh frame
    pix_q = '{24'h030201, 24'h060504, 24'h090807};
    obs_q.delete();
    begin
      int d0;
      d0 = done_seen;
      run_frame(32'h4000, 1'b1, 32'hFFFF_FFFF, 1'b0, 2, 1'b0);
      check("ab_no_done", 32'(done_seen), 32'(d0));
    end
    check("ab_nwr", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) check("ab_d0", obs_q[0].data, 32'h04030201);
    check("ab_cnt_holds", 32'(word_cnt_o), 32'd1);
    check("ab_idle", 32'(busy_o), 32'd0);
    pix_q = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};
    obs_q.delete();
    run_frame(32'h2000, 1'b1, 32'hFFFF_FFFF, 1'b0, -1, 1'b0);
    if (obs_q.size() > 0) begin
      check("ab_next_a0", obs_q[0].addr, 32'h2000);
      check("ab_next_d0", obs_q[0].data, 32'h04030201);
    end else begin
      check("ab_next_nwr", 32'd0, 32'd3);
    end

    // ---------------- address wrap and counter saturation (padded)
    pix_q.delete();
    for (int i = 0; i < 20; i++) pix_q.push_back(24'(i + 1));
    obs_q.delete();
    run_frame(32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFFF, 1'b0, -1, 1'b0);
    if (obs_q.size() > 2) check("wrap_a2", obs_q[2].addr, 32'h0);
    check("sat_cnt", 32'(word_cnt_o), 32'(CNT_MAX));

`ifdef RAM_WR_BOUND_EN
    // ---------------- bound: base 0, limit 8, four padded pixels
    pix_q = '{24'h000001, 24'h000002, 24'h000003, 24'h000004};
    obs_q.delete();
    run_frame(32'h0, 1'b0, 32'h8, 1'b0, -1, 1'b0);
    check("bnd_nwr", 32'(obs_q.size()), 32'd2);
    check("bnd_cnt", 32'(word_cnt_o), 32'd2);
    check("bnd_err", 32'(err_o), 32'd1);
    pix_q.delete();
    run_frame(32'h100, 1'b0, 32'hFFFF_FFFF, 1'b0, -1, 1'b0);
    check("bnd_err_cleared", 32'(err_o), 32'd0);
`endif

    // ---------------- asynchronous reset mid-frame
    start_frame(32'h3000, 1'b1, 32'hFFFF_FFFF);
    feed(24'h111111, 1'b0);
    feed(24'h222222, 1'b0);
    feed(24'h333333, 1'b0);
    #1;
    check("pre_rst_en", 32'(ram_en_o), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_done_cyc = -1;
    err_exp      = 1'b0;
    run_i        = 1'b0;
    check("arst_en", 32'(ram_en_o), 32'd0);
    check("arst_wr_en", 32'(ram_wr_en_o), 32'd0);
    check("arst_dout", ram_dout_o, 32'd0);
    check("arst_addr", ram_addr_o, 32'd0);
    check("arst_cnt", 32'(word_cnt_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_idle", 32'(busy_o), 32'd0);
    check("post_rst_done", 32'(done_o), 32'd0);

    // ---------------- randomized frames
    for (int f = 0; f < 40; f++) begin
      int          n;
      int          ab;
      logic [31:0] base;
      pix_q.delete();
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) pix_q.push_back(24'($urandom));
      base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 + 32'($urandom_range(0, 15) * 4))
                                         : $urandom;
      ab = ($urandom_range(0, 6) == 0) ? $urandom_range(0, n) : -1;
      run_frame(base, 1'($urandom), 32'hFFFF_FFFF, 1'($urandom), ab, 1'b1);
    end

    repeat (3) step();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
